// File: rtl/apb_mbox_arb.sv
// apb_mbox_arb: round-robin arbiter that bridges two req/done mailbox masters onto one APB master port.
// Define APB_MBOX_ARB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES wait cycles.
module apb_mbox_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [11:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [11:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [11:0] paddr,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata,
  input  logic [1:0]  pslverr
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("apb_mbox_arb: TIMEOUT_CYCLES must lie in 1..255");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;
  logic   last_m1;     // 1 = m1 was granted last, so m0 wins a tie
  logic   cur_m1;      // owner of the transfer in flight
  logic   elig0_c, elig1_c;
  logic   grant_c, grant_m1_c, complete_c, timeout_c;
  logic   xfer_err_c, rd_capture_c;

  // A request still high during its own done pulse is not eligible again.
  assign elig0_c = m0_req & ~m0_done;
  assign elig1_c = m1_req & ~m1_done;

`ifdef APB_MBOX_ARB_TIMEOUT_EN
  localparam int unsigned CW = 8;
  logic [CW-1:0] wait_cnt;

  // Consecutive pready=0 cycles of the current ACCESS phase.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign timeout_c = (state == ACCESS) && !pready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  assign xfer_err_c   = timeout_c | (|pslverr);
  assign rd_capture_c = ~pwrite & ~timeout_c;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state plus grant/complete strobes.
  always_comb begin
    state_nxt  = state;
    grant_c    = 1'b0;
    grant_m1_c = 1'b0;
    complete_c = 1'b0;
    case (state)
      IDLE: begin
        if (elig0_c || elig1_c) begin
          grant_c    = 1'b1;
          grant_m1_c = elig1_c & (~elig0_c | ~last_m1);
          state_nxt  = SETUP;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (pready || timeout_c) begin
          complete_c = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered APB drive, grant latch and per-master completion status.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      last_m1  <= 1'b1;
      cur_m1   <= 1'b0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      psel    <= (state_nxt != IDLE);
      penable <= (state_nxt == ACCESS);
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      if (grant_c) begin
        cur_m1  <= grant_m1_c;
        last_m1 <= grant_m1_c;
        pwrite  <= grant_m1_c ? m1_write : m0_write;
        paddr   <= grant_m1_c ? m1_addr  : m0_addr;
        pwdata  <= grant_m1_c ? m1_wdata : m0_wdata;
      end else if (state_nxt == IDLE) begin
        pwrite <= 1'b0;
        paddr  <= '0;
        pwdata <= '0;
      end
      if (complete_c) begin
        if (cur_m1) begin
          m1_done <= 1'b1;
          m1_err  <= xfer_err_c;
          if (rd_capture_c) m1_rdata <= prdata;
        end else begin
          m0_done <= 1'b1;
          m0_err  <= xfer_err_c;
          if (rd_capture_c) m0_rdata <= prdata;
        end
      end
    end
  end

endmodule
